atomik_acc_sched: RTL and testbench
===================================

ATOMIK_ACC_SCHED -- requirements
Module: atomik_acc_sched

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 N_REQ, 2, number of requesters (legal 2..4)
 READ_LAT, 2, wait cycles between READ accept and state sample (legal 1..7)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
 sys_clk  in  1  clock
 sys_rst_n  in  1  reset, asynchronous, active-low
 req_valid  in  N_REQ  per-requester request valid
 req_op  in  2*N_REQ  per-requester op: 00 ACCUM, 01 LOAD, 10 READ, 11 reserved
 req_data  in  64*N_REQ  per-requester operand (slice i = bits 64i+63:64i)
 req_ready  out  N_REQ  per-requester accept; transfer when valid&ready
 acc_delta_valid  out  1  one-cycle delta strobe to accumulator core
 acc_delta_in  out  64  delta value
 acc_load_initial  out  1  one-cycle load strobe to accumulator core
 acc_initial_state_in  out  64  load value
 acc_current_state  in  64  accumulator reconstructed state
 rsp_valid  out  N_REQ  one-cycle read-response strobe to the issuing requester
 rsp_data  out  64  read response data
 busy  out  1  high whenever state is not ARB
 err_op  out  1  one-cycle pulse on acceptance of a reserved op
 ops_issued  out  16  count of accepted ACCUM+LOAD ops, wraps at 16'hFFFF->0

Function
REQ-003 FSM states SHALL be ARB, RD_WAIT, RESP.
REQ-004 In ARB, req_ready SHALL be one-hot at most, given combinationally to the first valid requester found scanning upward (modulo N_REQ) from rr_ptr; all other ready bits 0.
REQ-005 On any accept from requester g, rr_ptr SHALL become (g+1) mod N_REQ; with no accept rr_ptr SHALL hold.
REQ-006 ACCUM accepted in cycle T: acc_delta_valid=1 and acc_delta_in=operand in cycle T+1 (registered); FSM stays ARB; back-to-back accepts every cycle allowed.
REQ-007 LOAD accepted in cycle T: acc_load_initial=1 and acc_initial_state_in=operand in cycle T+1; FSM stays ARB.
REQ-008 acc_delta_valid and acc_load_initial SHALL never both be 1 in one cycle; data outputs hold last value when strobes are 0.
REQ-009 READ accepted in cycle T: FSM to RD_WAIT for READ_LAT cycles (T+1..T+READ_LAT), req_ready all 0; at end of cycle T+READ_LAT rsp_data <= acc_current_state; FSM to RESP.
REQ-010 In RESP (cycle T+READ_LAT+1): rsp_valid[g]=1 for the READ's issuer only, rsp_data stable; FSM returns to ARB next cycle; req_ready 0 during RESP.
REQ-011 A READ accepted the cycle after an ACCUM/LOAD SHALL return state including that op (ordering guaranteed by READ_LAT>=1 and core's one-cycle update).
REQ-012 Reserved op 11: accepted, discarded, err_op=1 in cycle T+1, no accumulator strobe, ops_issued unchanged, FSM stays ARB.
REQ-013 ops_issued SHALL increment by 1 in cycle T+1 for each accepted ACCUM or LOAD.
REQ-014 rsp_data SHALL hold its value outside RESP until next sample.
REQ-015 Requester with valid high but op changing before accept: op sampled only at the accept cycle.

Reset
REQ-016 On sys_rst_n low (any state, including RD_WAIT/RESP): FSM=ARB, rr_ptr=0, all strobes/rsp_valid/err_op=0, acc_delta_in=acc_initial_state_in=rsp_data=0, ops_issued=0, busy=0; an in-flight READ is dropped with no response.
REQ-017 Reset assertion SHALL act asynchronously; deassertion takes effect on the next sys_clk edge.

Verification
REQ-018 Both requesters ACCUM continuously with operands 0x1,0x2 -> grants alternate 0,1,0,1; acc_delta_valid high every cycle; ops_issued=8 after 8 accepts.
REQ-019 Req0 LOAD 0xAAAA_0000_0000_5555, next cycle req0 READ (READ_LAT=2) -> rsp_valid[0] exactly 3 cycles after READ accept, rsp_data=0xAAAA_0000_0000_5555.
REQ-020 Req1 ACCUM 0xFF then immediately READ after load 0x0F -> rsp_data=0xF0, rsp_valid[1] only; req_ready all 0 during RD_WAIT/RESP.
REQ-021 Req0 op 11 -> err_op one pulse, no acc strobes, ops_issued unchanged, req1 granted next.
REQ-022 Reset asserted during RD_WAIT -> no rsp_valid, all outputs at REQ-016 values, first post-reset grant to requester 0.

Source files
------------

// File: rtl/atomik_acc_sched.sv
// Round-robin arbiter that turns requester ACCUM/LOAD/READ ops into
// accumulator-core strobes and returns read data to the issuing requester.
module atomik_acc_sched #(
    parameter int N_REQ    = 2,
    parameter int READ_LAT = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [2*N_REQ-1:0]   req_op,
    input  logic [64*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 acc_delta_valid,
    output logic [63:0]          acc_delta_in,
    output logic                 acc_load_initial,
    output logic [63:0]          acc_initial_state_in,
    input  logic [63:0]          acc_current_state,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [63:0]          rsp_data,
    output logic                 busy,
    output logic                 err_op,
    output logic [15:0]          ops_issued
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] OP_ACCUM = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [1:0] {
        ARB,
        RD_WAIT,
        RESP
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      rr_ptr_d;
    logic [IW-1:0]      rd_idx_q;
    logic [2:0]         cnt_q;
    logic [15:0]        ops_q;
    logic [15:0]        ops_d;
    logic               dv_q;
    logic [63:0]        din_q;
    logic               ld_q;
    logic [63:0]        ldv_q;
    logic [N_REQ-1:0]   rsp_v_q;
    logic [63:0]        rsp_d_q;
    logic               err_q;

    logic               gnt_found;
    logic [IW-1:0]      gnt_idx;
    logic [1:0]         gnt_op;
    logic [63:0]        gnt_data;
    logic [N_REQ-1:0]   rsp_onehot;

    // Scan upward from rr_ptr; the first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        if (state_q == ARB) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % N_REQ;
                if (!gnt_found && req_valid[idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = IW'(idx);
                end
            end
        end
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign gnt_op   = req_op[2*int'(gnt_idx) +: 2];
    assign gnt_data = req_data[64*int'(gnt_idx) +: 64];

    assign rr_ptr_d = gnt_found
                    ? IW'((int'(gnt_idx) + 1) % N_REQ)
                    : rr_ptr_q;

    assign ops_d = ops_q + 16'(gnt_found &&
                   (gnt_op == OP_ACCUM || gnt_op == OP_LOAD));

    assign rsp_onehot = N_REQ'(1) << rd_idx_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            ops_q    <= '0;
            dv_q     <= 1'b0;
            din_q    <= '0;
            ld_q     <= 1'b0;
            ldv_q    <= '0;
            rsp_v_q  <= '0;
            rsp_d_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            dv_q     <= 1'b0;
            ld_q     <= 1'b0;
            err_q    <= 1'b0;
            rsp_v_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
            ops_q    <= ops_d;
            unique case (state_q)
                ARB: begin
                    if (gnt_found) begin
                        unique case (gnt_op)
                            OP_ACCUM: begin
                                dv_q  <= 1'b1;
                                din_q <= gnt_data;
                            end
                            OP_LOAD: begin
                                ld_q  <= 1'b1;
                                ldv_q <= gnt_data;
                            end
                            OP_READ: begin
                                state_q  <= RD_WAIT;
                                cnt_q    <= 3'(READ_LAT - 1);
                                rd_idx_q <= gnt_idx;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        rsp_d_q <= acc_current_state;
                        rsp_v_q <= rsp_onehot;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: state_q <= ARB;
                default: state_q <= ARB;
            endcase
        end
    end

    assign acc_delta_valid      = dv_q;
    assign acc_delta_in         = din_q;
    assign acc_load_initial     = ld_q;
    assign acc_initial_state_in = ldv_q;
    assign rsp_valid            = rsp_v_q;
    assign rsp_data             = rsp_d_q;
    assign err_op               = err_q;
    assign ops_issued           = ops_q;
    assign busy                 = (state_q != ARB);

endmodule

// File: tb/tb_atomik_acc_sched.sv
// Directed bench for atomik_acc_sched with an XOR-delta accumulator core model.
module tb_atomik_acc_sched;

    logic         sys_clk;
    logic         sys_rst_n;
    logic [1:0]   req_valid;
    logic [3:0]   req_op;
    logic [127:0] req_data;
    logic [1:0]   req_ready;
    logic         acc_delta_valid;
    logic [63:0]  acc_delta_in;
    logic         acc_load_initial;
    logic [63:0]  acc_initial_state_in;
    logic [63:0]  acc_current_state;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_data;
    logic         busy;
    logic         err_op;
    logic [15:0]  ops_issued;

    int total = 0;
    int bad   = 0;

    atomik_acc_sched #(.N_REQ(2), .READ_LAT(2)) dut (
        .sys_clk              (sys_clk),
        .sys_rst_n            (sys_rst_n),
        .req_valid            (req_valid),
        .req_op               (req_op),
        .req_data             (req_data),
        .req_ready            (req_ready),
        .acc_delta_valid      (acc_delta_valid),
        .acc_delta_in         (acc_delta_in),
        .acc_load_initial     (acc_load_initial),
        .acc_initial_state_in (acc_initial_state_in),
        .acc_current_state    (acc_current_state),
        .rsp_valid            (rsp_valid),
        .rsp_data             (rsp_data),
        .busy                 (busy),
        .err_op               (err_op),
        .ops_issued           (ops_issued)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Core model: load overrides, deltas fold in by XOR, one-cycle update.
    logic [63:0] core_q;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            core_q <= '0;
        else if (acc_load_initial)
            core_q <= acc_initial_state_in;
        else if (acc_delta_valid)
            core_q <= core_q ^ acc_delta_in;
    end
    assign acc_current_state = core_q;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_ops", 64'(ops_issued), 64'h0);
        check("rst_rspv", 64'(rsp_valid), 64'h0);
        check("rst_rspd", rsp_data, 64'h0);
        check("rst_dv", 64'(acc_delta_valid), 64'h0);
        sys_rst_n = 1'b1;
        tick();

        // Two continuous ACCUM requesters alternate.
        req_valid = 2'b11;
        req_op    = 4'b0000;
        req_data  = {64'h2, 64'h1};
        #1;
        for (int i = 0; i < 8; i++) begin
            check("rr_ready", 64'(req_ready),
                  (i % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            check("rr_dv", 64'(acc_delta_valid), 64'h1);
            check("rr_din", acc_delta_in,
                  (i % 2 == 0) ? 64'h1 : 64'h2);
            check("rr_ops", 64'(ops_issued), 64'(i + 1));
        end
        req_valid = '0;
        tick();
        check("idle_dv", 64'(acc_delta_valid), 64'h0);
        check("idle_din_hold", acc_delta_in, 64'h2);

        // LOAD then READ from requester 0.
        req_valid      = 2'b01;
        req_op[1:0]    = 2'b01;
        req_data[63:0] = 64'hAAAA_0000_0000_5555;
        #1;
        check("ld_ready", 64'(req_ready), 64'h1);
        tick();
        check("ld_strobe", 64'(acc_load_initial), 64'h1);
        check("ld_val", acc_initial_state_in, 64'hAAAA_0000_0000_5555);
        check("ld_no_dv", 64'(acc_delta_valid), 64'h0);
        check("ld_ops", 64'(ops_issued), 64'd9);
        req_op[1:0] = 2'b10;
        #1;
        check("rd0_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        check("rd0_busy", 64'(busy), 64'h1);
        check("rd0_t1", 64'(rsp_valid), 64'h0);
        tick();
        check("rd0_t2", 64'(rsp_valid), 64'h0);
        tick();
        check("rd0_t3_v", 64'(rsp_valid), 64'h1);
        check("rd0_t3_d", rsp_data, 64'hAAAA_0000_0000_5555);
        tick();
        check("rd0_t4_v", 64'(rsp_valid), 64'h0);
        check("rd0_t4_busy", 64'(busy), 64'h0);
        check("rd0_hold", rsp_data, 64'hAAAA_0000_0000_5555);

        // Requester 1: LOAD 0x0F, ACCUM 0xFF, READ -> 0xF0.
        req_valid        = 2'b10;
        req_op[3:2]      = 2'b01;
        req_data[127:64] = 64'h0F;
        #1;
        check("r1_ld_ready", 64'(req_ready), 64'h2);
        tick();
        req_op[3:2]      = 2'b00;
        req_data[127:64] = 64'hFF;
        #1;
        check("r1_ac_ready", 64'(req_ready), 64'h2);
        tick();
        check("r1_ac_din", acc_delta_in, 64'hFF);
        req_op[3:2] = 2'b10;
        #1;
        check("r1_rd_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid   = 2'b11;
        req_op      = 4'b0000;
        #1;
        check("r1_wait1_ready", 64'(req_ready), 64'h0);
        check("r1_busy", 64'(busy), 64'h1);
        tick();
        check("r1_wait2_ready", 64'(req_ready), 64'h0);
        tick();
        check("r1_resp_ready", 64'(req_ready), 64'h0);
        check("r1_resp_v", 64'(rsp_valid), 64'h2);
        check("r1_resp_d", rsp_data, 64'hF0);
        req_valid = '0;
        tick();
        check("r1_after_v", 64'(rsp_valid), 64'h0);
        check("r1_ops", 64'(ops_issued), 64'd11);

        // Reserved op from requester 0.
        req_valid        = 2'b11;
        req_op           = 4'b0011;
        req_data[127:64] = 64'h3;
        #1;
        check("err_ready", 64'(req_ready), 64'h1);
        tick();
        check("err_pulse", 64'(err_op), 64'h1);
        check("err_no_dv", 64'(acc_delta_valid), 64'h0);
        check("err_no_ld", 64'(acc_load_initial), 64'h0);
        check("err_ops", 64'(ops_issued), 64'd11);
        check("err_next_gnt", 64'(req_ready), 64'h2);
        req_valid = 2'b10;
        tick();
        check("err_clear", 64'(err_op), 64'h0);
        check("err_r1_din", acc_delta_in, 64'h3);
        check("err_r1_ops", 64'(ops_issued), 64'd12);
        req_valid = '0;

        // Reset while a READ is waiting.
        req_valid   = 2'b01;
        req_op[1:0] = 2'b10;
        #1;
        check("rst_rd_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        check("rst_rd_busy", 64'(busy), 64'h1);
        tick();
        sys_rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_ops", 64'(ops_issued), 64'h0);
        check("arst_rspd", rsp_data, 64'h0);
        check("arst_din", acc_delta_in, 64'h0);
        check("arst_ldv", acc_initial_state_in, 64'h0);
        tick();
        check("arst_rspv1", 64'(rsp_valid), 64'h0);
        tick();
        check("arst_rspv2", 64'(rsp_valid), 64'h0);
        sys_rst_n = 1'b1;
        req_valid = 2'b11;
        req_op    = 4'b0000;
        req_data  = {64'h6, 64'h5};
        #1;
        check("post_rst_gnt", 64'(req_ready), 64'h1);
        tick();
        check("post_rst_din", acc_delta_in, 64'h5);
        check("post_rst_rspv", 64'(rsp_valid), 64'h0);
        check("post_rst_ops", 64'(ops_issued), 64'h1);
        req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
